arith_unit_seq: RTL and testbench



---
 rtl/arith_unit_seq_if.sv | 37 +++
 rtl/arith_unit_seq.sv | 169 ++++++++++++++++
 tb/tb_arith_unit_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/arith_unit_seq_if.sv
// Operand/result handshake bundle for arith_unit_seq; the sat input exists only
// when ARITH_SAT_EN is defined.
interface arith_unit_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
`ifdef ARITH_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
`ifdef ARITH_SAT_EN
        output sat,
`endif
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
`ifdef ARITH_SAT_EN
        input  sat,
`endif
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/arith_unit_seq.sv
// Multi-cycle ADD/SUB/SLT/SLTU, CHUNK bits per cycle through a carry register.
// ARITH_SAT_EN adds the sat input and saturating ADD/SUB; otherwise results wrap.
module arith_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    arith_unit_seq_if.slave bus
);
    localparam int NCH   = WIDTH / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCH - 1);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [1:0]       op_p0;
`ifdef ARITH_SAT_EN
    logic             sat_p0;
`endif
    logic [WIDTH-1:0] res_p1;
    logic             z_p1, n_p1, c_p1, v_p1;
    logic             vld_p1;

    logic [CHUNK-1:0] ca, cb;
    logic [CHUNK:0]   csum;
    logic             last;
    logic             cin_msb;
    logic             raw_v;
    logic             slt_bit;
    logic [WIDTH-1:0] raw_full;
    logic [WIDTH-1:0] fin_res;
    int unsigned      base;

`ifdef ARITH_SAT_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp toward the sign of A: on overflow the true result lies beyond that end.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             a_neg,
                                                  input logic             ovf);
        if (!ovf) return raw;
        return a_neg ? SAT_MIN : SAT_MAX;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = BUSY;
            BUSY:    if (last)         state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = vld_p1;
    assign bus.result    = res_p1;
    assign bus.flag_z    = z_p1;
    assign bus.flag_n    = n_p1;
    assign bus.flag_c    = c_p1;
    assign bus.flag_v    = v_p1;

    // Chunk adder: one CHUNK-wide slice per BUSY cycle
    always_comb begin
        last     = (cnt_q == CNT_LAST);
        base     = 32'(cnt_q) * 32'(CHUNK);
        ca       = a_p0[base +: CHUNK];
        cb       = b_p0[base +: CHUNK];
        csum     = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
        // Carry into a bit position is recovered from its sum bit and operand bits.
        cin_msb  = csum[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
        raw_v    = cin_msb ^ csum[CHUNK];
        raw_full = res_p1;
        raw_full[base +: CHUNK] = csum[CHUNK-1:0];
        slt_bit  = raw_full[WIDTH-1] ^ raw_v;

        fin_res = raw_full;
        case (op_p0)
            OP_ADD, OP_SUB: begin
`ifdef ARITH_SAT_EN
                fin_res = sat_p0 ? saturate(raw_full, a_p0[WIDTH-1], raw_v) : raw_full;
`else
                fin_res = raw_full;
`endif
            end
            OP_SLT:  fin_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU: fin_res = {{(WIDTH-1){1'b0}}, ~csum[CHUNK]};
            default: fin_res = raw_full;
        endcase
    end

    // Operand latch (_p0) and result/flag register (_p1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_p0    <= '0;
            b_p0    <= '0;
            op_p0   <= OP_ADD;
`ifdef ARITH_SAT_EN
            sat_p0  <= 1'b0;
`endif
            res_p1  <= '0;
            z_p1    <= 1'b0;
            n_p1    <= 1'b0;
            c_p1    <= 1'b0;
            v_p1    <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1; the +1 enters as the first carry.
                        a_p0    <= bus.a;
                        b_p0    <= (bus.op != OP_ADD) ? ~bus.b : bus.b;
                        carry_q <= (bus.op != OP_ADD);
                        op_p0   <= bus.op;
`ifdef ARITH_SAT_EN
                        sat_p0  <= bus.sat;
`endif
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    carry_q <= csum[CHUNK];
                    if (last) begin
                        res_p1 <= fin_res;
                        z_p1   <= (fin_res == '0);
                        n_p1   <= raw_full[WIDTH-1];
                        c_p1   <= csum[CHUNK];
                        v_p1   <= raw_v;
                        vld_p1 <= 1'b1;
                        cnt_q  <= '0;
                    end else begin
                        res_p1 <= raw_full;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) vld_p1 <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_arith_unit_seq.sv
// Randomized and directed bench for arith_unit_seq against a plain-arithmetic model;
// saturation cases are exercised when ARITH_SAT_EN is defined.
`timescale 1ns/1ps
module tb_arith_unit_seq;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int LAT   = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    arith_unit_seq_if #(.WIDTH(WIDTH)) bus ();

    arith_unit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        z, n, c, v;
    } expect_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic expect_t model(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] op, input logic sat);
        expect_t            e;
        logic [32:0]        full;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (op == 2'b00) full = {1'b0, a} + {1'b0, b};
        else             full = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.c = full[32];
        e.n = full[31];
        if (op == 2'b00) e.v = (a[31] == b[31]) && (full[31] != a[31]);
        else             e.v = (a[31] != b[31]) && (full[31] != a[31]);
        case (op)
            2'b10:   e.res = (sa < sb) ? 32'd1 : 32'd0;
            2'b11:   e.res = (a < b)   ? 32'd1 : 32'd0;
            default: begin
                e.res = full[31:0];
                if (sat && e.v) e.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic sat, input int hold);
        expect_t e;
        int      lat;
        e = model(a, b, op, sat);
        @(negedge clk);
        check({tag, ":in_ready_idle"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
`ifdef ARITH_SAT_EN
        bus.sat      = sat;
`endif
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.op       = 2'($urandom);
        check({tag, ":in_ready_busy"}, bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat <= 4 * LAT) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, ":latency"}, lat, LAT);
        if (!bus.out_valid) return;
        check({tag, ":result"}, bus.result, e.res);
        check({tag, ":z"}, bus.flag_z, e.z);
        check({tag, ":n"}, bus.flag_n, e.n);
        check({tag, ":c"}, bus.flag_c, e.c);
        check({tag, ":v"}, bus.flag_v, e.v);
        check({tag, ":in_ready_done"}, bus.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a        = $urandom;
            @(posedge clk);
            @(negedge clk);
            check({tag, ":hold_valid"}, bus.out_valid, 1);
            check({tag, ":hold_ready"}, bus.in_ready, 0);
            check({tag, ":hold_result"}, bus.result, e.res);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ":drain_valid"}, bus.out_valid, 0);
        check({tag, ":drain_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        int          seen;
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        logic        rsat;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 2'b00;
        bus.out_ready = 1'b0;
`ifdef ARITH_SAT_EN
        bus.sat       = 1'b0;
`endif
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst:in_ready", bus.in_ready, 1);
        check("rst:out_valid", bus.out_valid, 0);
        check("rst:result", bus.result, 0);
        check("rst:flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 0);
        rst_n = 1'b1;

        run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 2'b00, 1'b0, 0);
        run_op("sub_eq", 32'h5, 32'h5, 2'b01, 1'b0, 0);
        run_op("sub_borrow", 32'h0, 32'h1, 2'b01, 1'b0, 1);
        run_op("slt_neg", 32'h8000_0000, 32'h1, 2'b10, 1'b0, 0);
        run_op("sltu_neg", 32'h8000_0000, 32'h1, 2'b11, 1'b0, 0);
        run_op("slt_vcase", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b10, 1'b0, 0);
        run_op("backpressure", 32'h3, 32'h4, 2'b00, 1'b0, 3);

        // Reset two cycles into BUSY must abort without producing a result.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h0F0F_0F0F;
        bus.op       = 2'b00;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort:out_valid", bus.out_valid, 0);
        check("abort:in_ready", bus.in_ready, 1);
        check("abort:result", bus.result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort:no_output", seen, 0);
        run_op("after_abort", 32'hFF, 32'h1, 2'b00, 1'b0, 0);

`ifdef ARITH_SAT_EN
        run_op("sat_add", 32'h7FFF_FFFF, 32'h1, 2'b00, 1'b1, 0);
        run_op("sat_sub", 32'h8000_0000, 32'h1, 2'b01, 1'b1, 0);
        run_op("nosat_add", 32'h7FFF_FFFF, 32'h1, 2'b00, 1'b0, 0);
        run_op("sat_slt", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b10, 1'b1, 0);
`endif

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'h7FFF_FFFF;
                1:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       rb = 32'hFFFF_FFFF;
                1:       rb = ra;
                2:       rb = 32'h1;
                default: rb = $urandom;
            endcase
            rop = 2'($urandom);
`ifdef ARITH_SAT_EN
            rsat = 1'($urandom);
`else
            rsat = 1'b0;
`endif
            run_op("random", ra, rb, rop, rsat, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed simulation still running, expected completion");
        $fatal(1, "timeout");
    end
endmodule
